// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants, FSM encoding and decoded-instruction payload for the ALU issue controller.
package alu_issue_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPRN_W = 6;
    localparam int unsigned OPC_W  = 6;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OPC_SLTI  = 6'h0A;
    localparam logic [OPC_W-1:0] OPC_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OPC_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OPC_LUI   = 6'h0F;
    localparam logic [OPC_W-1:0] OPC_MULI  = 6'h1D;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h01;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_MUL = 6'h2C;

    localparam logic [OPRN_W-1:0] ALU_NOP = 6'd0;
    localparam logic [OPRN_W-1:0] ALU_ADD = 6'd1;
    localparam logic [OPRN_W-1:0] ALU_SUB = 6'd2;
    localparam logic [OPRN_W-1:0] ALU_MUL = 6'd3;
    localparam logic [OPRN_W-1:0] ALU_SHR = 6'd4;
    localparam logic [OPRN_W-1:0] ALU_SHL = 6'd5;
    localparam logic [OPRN_W-1:0] ALU_AND = 6'd6;
    localparam logic [OPRN_W-1:0] ALU_OR  = 6'd7;
    localparam logic [OPRN_W-1:0] ALU_NOR = 6'd8;
    localparam logic [OPRN_W-1:0] ALU_SLT = 6'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [OPRN_W-1:0] oprn;
        logic              is_mul;
        logic              is_beq;
        logic              is_bne;
        logic              illegal;
    } dec_t;

    function automatic dec_t mk_dec(input logic [DATA_W-1:0] op1,
                                    input logic [DATA_W-1:0] op2,
                                    input logic [OPRN_W-1:0] oprn);
        dec_t d;
        d      = '0;
        d.op1  = op1;
        d.op2  = op2;
        d.oprn = oprn;
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-issue, ALU and writeback signals of the ALU issue controller.
interface alu_issue_ctrl_if;
    import alu_issue_ctrl_pkg::*;

    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] INSTR;
    logic [DATA_W-1:0] RS_DATA;
    logic [DATA_W-1:0] RT_DATA;
    logic [DATA_W-1:0] ALU_OP1;
    logic [DATA_W-1:0] ALU_OP2;
    logic [OPRN_W-1:0] ALU_OPRN;
    logic [DATA_W-1:0] ALU_OUT;
    logic              ALU_ZERO;
    logic              RES_VALID;
    logic              RES_READY;
    logic [DATA_W-1:0] RES_DATA;
    logic              RES_ZERO;
    logic              BR_TAKEN;
    logic              ILLEGAL;

    modport master (
        output IN_VALID, INSTR, RS_DATA, RT_DATA, ALU_OUT, ALU_ZERO, RES_READY,
        input  IN_READY, ALU_OP1, ALU_OP2, ALU_OPRN, RES_VALID, RES_DATA, RES_ZERO,
               BR_TAKEN, ILLEGAL
    );

    modport slave (
        input  IN_VALID, INSTR, RS_DATA, RT_DATA, ALU_OUT, ALU_ZERO, RES_READY,
        output IN_READY, ALU_OP1, ALU_OP2, ALU_OPRN, RES_VALID, RES_DATA, RES_ZERO,
               BR_TAKEN, ILLEGAL
    );

endinterface

// File: rtl/alu_instr_decode.sv
// Combinational decode of one instruction word into ALU operands, operation and flags.
module alu_instr_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output dec_t              dec_c
);

    logic [OPC_W-1:0]  opc;
    logic [5:0]        fn;
    logic [15:0]       imm;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] shamt;
    logic              unused_fields_c;

    assign opc   = instr[31:26];
    assign fn    = instr[5:0];
    assign imm   = instr[15:0];
    assign sext  = {{16{imm[15]}}, imm};
    assign zext  = DATA_W'(imm);
    assign shamt = DATA_W'(instr[10:6]);
    // Register-number fields are resolved upstream; only their values arrive here.
    assign unused_fields_c = ^instr[25:16];

    always_comb begin
        dec_c         = '0;
        dec_c.illegal = 1'b1;
        case (opc)
            OPC_RTYPE: begin
                case (fn)
                    FN_ADD:  dec_c = mk_dec(rs, rt, ALU_ADD);
                    FN_SUB:  dec_c = mk_dec(rs, rt, ALU_SUB);
                    FN_MUL:  dec_c = mk_dec(rs, rt, ALU_MUL);
                    FN_AND:  dec_c = mk_dec(rs, rt, ALU_AND);
                    FN_OR:   dec_c = mk_dec(rs, rt, ALU_OR);
                    FN_NOR:  dec_c = mk_dec(rs, rt, ALU_NOR);
                    FN_SLT:  dec_c = mk_dec(rs, rt, ALU_SLT);
                    FN_SLL:  dec_c = mk_dec(rt, shamt, ALU_SHL);
                    FN_SRL:  dec_c = mk_dec(rt, shamt, ALU_SHR);
                    default: ;
                endcase
            end
            OPC_ADDI, OPC_LW, OPC_SW: dec_c = mk_dec(rs, sext, ALU_ADD);
            OPC_MULI: dec_c = mk_dec(rs, sext, ALU_MUL);
            OPC_SLTI: dec_c = mk_dec(rs, sext, ALU_SLT);
            OPC_ANDI: dec_c = mk_dec(rs, zext, ALU_AND);
            OPC_ORI:  dec_c = mk_dec(rs, zext, ALU_OR);
            OPC_LUI:  dec_c = mk_dec({imm, 16'h0000}, DATA_W'(0), ALU_OR);
            OPC_BEQ: begin
                dec_c        = mk_dec(rs, rt, ALU_SUB);
                dec_c.is_beq = 1'b1;
            end
            OPC_BNE: begin
                dec_c        = mk_dec(rs, rt, ALU_SUB);
                dec_c.is_bne = 1'b1;
            end
            default: ;
        endcase
        dec_c.is_mul = !dec_c.illegal && (dec_c.oprn == ALU_MUL);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage front end: issues one instruction to the combinational ALU, waits out
// its settle window, captures the result and hands it to writeback over valid/ready.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned MUL_CYC    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    alu_issue_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MUL_CYC + 1);

    state_t            state_q, state_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    dec_t              dec_c;
    logic              accept_c, capture_c;

    logic              in_ready_q, in_ready_nx;
    logic              res_valid_q, res_valid_nx;
    logic [OPRN_W-1:0] oprn_q, oprn_nx;
    logic [DATA_W-1:0] op1_q, op1_nx, op2_q, op2_nx;
    logic [DATA_W-1:0] res_data_q, res_data_nx;
    logic              res_zero_q, res_zero_nx;
    logic              br_q, br_nx;
    logic              ill_q, ill_nx;
    logic              pend_beq_q, pend_beq_nx, pend_bne_q, pend_bne_nx;
    logic              pend_ill_q, pend_ill_nx;

    alu_instr_decode u_decode (
        .instr (bus.INSTR),
        .rs    (bus.RS_DATA),
        .rt    (bus.RT_DATA),
        .dec_c (dec_c)
    );

    assign accept_c  = (state_q == ST_IDLE) && bus.IN_VALID;
    assign capture_c = (state_q == ST_EXEC) && (cnt_q == CNT_W'(1));

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE: if (accept_c)      state_nx = ST_EXEC;
            ST_EXEC: if (capture_c)     state_nx = ST_DONE;
            ST_DONE: if (bus.RES_READY) state_nx = ST_IDLE;
            default:                    state_nx = ST_IDLE;
        endcase
    end

    // Illegal instructions pass one dead EXEC cycle with OPRN held at no-op.
    always_comb begin
        in_ready_nx  = (state_nx == ST_IDLE);
        res_valid_nx = (state_nx == ST_DONE);
        cnt_nx       = cnt_q;
        oprn_nx      = oprn_q;
        op1_nx       = op1_q;
        op2_nx       = op2_q;
        pend_beq_nx  = pend_beq_q;
        pend_bne_nx  = pend_bne_q;
        pend_ill_nx  = pend_ill_q;
        res_data_nx  = res_data_q;
        res_zero_nx  = res_zero_q;
        br_nx        = br_q;
        ill_nx       = ill_q;
        if (accept_c) begin
            cnt_nx      = dec_c.illegal ? CNT_W'(1)
                        : dec_c.is_mul  ? CNT_W'(MUL_CYC) : CNT_W'(SETTLE_CYC);
            pend_beq_nx = dec_c.is_beq;
            pend_bne_nx = dec_c.is_bne;
            pend_ill_nx = dec_c.illegal;
            if (!dec_c.illegal) begin
                op1_nx  = dec_c.op1;
                op2_nx  = dec_c.op2;
                oprn_nx = dec_c.oprn;
            end
        end else if (state_q == ST_EXEC) begin
            cnt_nx = cnt_q - CNT_W'(1);
        end
        if (capture_c) begin
            oprn_nx     = ALU_NOP;
            res_data_nx = pend_ill_q ? DATA_W'(0) : bus.ALU_OUT;
            res_zero_nx = !pend_ill_q && bus.ALU_ZERO;
            br_nx       = (pend_beq_q && bus.ALU_ZERO) || (pend_bne_q && !bus.ALU_ZERO);
            ill_nx      = pend_ill_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            oprn_q      <= ALU_NOP;
            op1_q       <= '0;
            op2_q       <= '0;
            pend_beq_q  <= 1'b0;
            pend_bne_q  <= 1'b0;
            pend_ill_q  <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_nx;
            in_ready_q  <= in_ready_nx;
            res_valid_q <= res_valid_nx;
            oprn_q      <= oprn_nx;
            op1_q       <= op1_nx;
            op2_q       <= op2_nx;
            pend_beq_q  <= pend_beq_nx;
            pend_bne_q  <= pend_bne_nx;
            pend_ill_q  <= pend_ill_nx;
            res_data_q  <= res_data_nx;
            res_zero_q  <= res_zero_nx;
            br_q        <= br_nx;
            ill_q       <= ill_nx;
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.RES_VALID = res_valid_q;
    assign bus.ALU_OPRN  = oprn_q;
    assign bus.ALU_OP1   = op1_q;
    assign bus.ALU_OP2   = op2_q;
    assign bus.RES_DATA  = res_data_q;
    assign bus.RES_ZERO  = res_zero_q;
    assign bus.BR_TAKEN  = br_q;
    assign bus.ILLEGAL   = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed literal cases plus random traffic against a cycle-count model.
module tb_alu_issue_ctrl;

    localparam int unsigned SETTLE = 1;
    localparam int unsigned MULC   = 4;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.SETTLE_CYC(SETTLE), .MUL_CYC(MULC)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] op);
        case (op)
            6'd1: return a + b;
            6'd2: return a - b;
            6'd3: return a * b;
            6'd4: return a >> b;
            6'd5: return a << b;
            6'd6: return a & b;
            6'd7: return a | b;
            6'd8: return ~(a | b);
            6'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Environment ALU: purely combinational, fed by the DUT's operand outputs.
    assign bus.ALU_OUT  = ref_alu(bus.ALU_OP1, bus.ALU_OP2, bus.ALU_OPRN);
    assign bus.ALU_ZERO = (bus.ALU_OUT == 32'd0);

    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                       input logic [31:0] rt, output bit legal,
                                       output logic [5:0] oprn, output logic [31:0] a,
                                       output logic [31:0] b, output int n,
                                       output bit beq, output bit bne);
        logic [5:0]  op  = ins[31:26];
        logic [5:0]  fn  = ins[5:0];
        logic [15:0] imm = ins[15:0];
        logic [31:0] sx  = {{16{imm[15]}}, imm};
        logic [31:0] zx  = {16'h0000, imm};
        legal = 1; oprn = 0; a = rs; b = rt; beq = 0; bne = 0;
        if (op == 6'h00) begin
            case (fn)
                6'h20: oprn = 1;
                6'h22: oprn = 2;
                6'h2C: oprn = 3;
                6'h24: oprn = 6;
                6'h25: oprn = 7;
                6'h27: oprn = 8;
                6'h2A: oprn = 9;
                6'h01: begin oprn = 5; a = rt; b = {27'd0, ins[10:6]}; end
                6'h02: begin oprn = 4; a = rt; b = {27'd0, ins[10:6]}; end
                default: legal = 0;
            endcase
        end else begin
            case (op)
                6'h08, 6'h23, 6'h2B: begin oprn = 1; b = sx; end
                6'h1D: begin oprn = 3; b = sx; end
                6'h0A: begin oprn = 9; b = sx; end
                6'h0C: begin oprn = 6; b = zx; end
                6'h0D: begin oprn = 7; b = zx; end
                6'h0F: begin oprn = 7; a = {imm, 16'h0000}; b = 0; end
                6'h04: begin oprn = 2; beq = 1; end
                6'h05: begin oprn = 2; bne = 1; end
                default: legal = 0;
            endcase
        end
        n = (oprn == 3) ? int'(MULC) : int'(SETTLE);
    endfunction

    // Model: counts cycles since acceptance; the result becomes visible N edges later.
    int          m_left;
    bit          m_done, m_ill, m_fresh;
    logic [5:0]  m_oprn;
    logic [31:0] m_op1, m_op2, m_res;
    bit          m_zero, m_br;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_done = 0; m_ill = 0; m_fresh = 1; m_oprn = 0;
            m_op1 = 0; m_op2 = 0; m_res = 0; m_zero = 0; m_br = 0;
        end else if (m_done) begin
            if (bus.RES_READY) m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end else if (bus.IN_VALID) begin
            bit lg, bq, bn; logic [5:0] o; logic [31:0] a, b; int n;
            ref_decode(bus.INSTR, bus.RS_DATA, bus.RT_DATA, lg, o, a, b, n, bq, bn);
            m_fresh = 0;
            m_ill   = !lg;
            if (lg) begin
                m_oprn = o; m_op1 = a; m_op2 = b; m_left = n;
                m_res  = ref_alu(a, b, o);
                m_zero = (m_res == 0);
                m_br   = bq ? m_zero : (bn ? !m_zero : 1'b0);
            end else begin
                m_oprn = 0; m_left = 1; m_res = 0; m_zero = 0; m_br = 0;
            end
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [5:0] e_oprn;
            e_oprn = (m_left > 0 && !m_ill) ? m_oprn : 6'd0;
            chk("in_ready", 32'(bus.IN_READY), 32'(m_left == 0 && !m_done));
            chk("res_valid", 32'(bus.RES_VALID), 32'(m_done));
            chk("alu_oprn", 32'(bus.ALU_OPRN), 32'(e_oprn));
            if (e_oprn != 0) begin
                chk("alu_op1", bus.ALU_OP1, m_op1);
                chk("alu_op2", bus.ALU_OP2, m_op2);
            end
            if (m_done || m_fresh) begin
                chk("res_data", bus.RES_DATA, m_res);
                chk("res_zero", 32'(bus.RES_ZERO), 32'(m_zero));
                chk("br_taken", 32'(bus.BR_TAKEN), 32'(m_br));
                chk("illegal", 32'(bus.ILLEGAL), 32'(m_ill && m_done));
            end
        end
    end

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
        return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    task automatic do_txn(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                          input int stall, input bit hold, input bit lit,
                          input logic [31:0] xd, input bit xz, input bit xb, input bit xi,
                          input int xlat, input int xopc, input bit ck_op2,
                          input logic [31:0] xop2);
        int guard, lat, opc;
        logic [31:0] op2_seen;
        @(negedge clk);
        bus.IN_VALID = 1; bus.INSTR = instr; bus.RS_DATA = rs; bus.RT_DATA = rt;
        guard = 0;
        while (!bus.IN_READY && guard < 20) begin @(negedge clk); guard++; end
        if (guard >= 20) chk("accept_wait", 32'(bus.IN_READY), 32'd1);
        @(negedge clk);
        if (!hold) bus.IN_VALID = 0;
        op2_seen = bus.ALU_OP2;
        lat = 0; opc = 0;
        while (!bus.RES_VALID && lat < 40) begin
            if (bus.ALU_OPRN != 0) opc++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) chk("res_wait", 32'(bus.RES_VALID), 32'd1);
        for (int i = 0; i < stall; i++) begin
            if (lit) chk("stall_in_ready", 32'(bus.IN_READY), 32'd0);
            @(negedge clk);
        end
        if (lit) begin
            chk("lat", 32'(lat), 32'(xlat));
            chk("oprn_cycles", 32'(opc), 32'(xopc));
            chk("lit_data", bus.RES_DATA, xd);
            chk("lit_zero", 32'(bus.RES_ZERO), 32'(xz));
            chk("lit_br", 32'(bus.BR_TAKEN), 32'(xb));
            chk("lit_ill", 32'(bus.ILLEGAL), 32'(xi));
            if (ck_op2) chk("lit_op2", op2_seen, xop2);
        end
        bus.RES_READY = 1; bus.IN_VALID = 0;
        @(negedge clk);
        bus.RES_READY = 0;
        chk("in_ready_after", 32'(bus.IN_READY), 32'd1);
    endtask

    function automatic logic [31:0] rand_instr();
        int k = $urandom_range(0, 21);
        logic [15:0] imm = 16'($urandom);
        logic [4:0]  sh  = 5'($urandom);
        case (k)
            0:  return rtype(6'h20, sh);
            1:  return rtype(6'h22, sh);
            2:  return rtype(6'h2C, sh);
            3:  return rtype(6'h24, sh);
            4:  return rtype(6'h25, sh);
            5:  return rtype(6'h27, sh);
            6:  return rtype(6'h2A, sh);
            7:  return rtype(6'h01, sh);
            8:  return rtype(6'h02, sh);
            9:  return itype(6'h08, imm);
            10: return itype(6'h1D, imm);
            11: return itype(6'h0A, imm);
            12: return itype(6'h23, imm);
            13: return itype(6'h2B, imm);
            14: return itype(6'h0C, imm);
            15: return itype(6'h0D, imm);
            16: return itype(6'h0F, imm);
            17: return itype(6'h04, imm);
            18: return itype(6'h05, imm);
            19: return rtype(6'h08, 5'd0);
            20: return itype(6'h02, imm);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1;
        bus.IN_VALID = 0; bus.INSTR = 0; bus.RS_DATA = 0; bus.RT_DATA = 0; bus.RES_READY = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);
        chk("rst_res_valid", 32'(bus.RES_VALID), 32'd0);
        chk("rst_oprn", 32'(bus.ALU_OPRN), 32'd0);
        chk("rst_res_data", bus.RES_DATA, 32'd0);
        chk("rst_op1", bus.ALU_OP1, 32'd0);
        chk_en = 1;

        do_txn(rtype(6'h20, 0), 5, 7, 0, 0, 1, 32'd12, 0, 0, 0, 1, 1, 0, 0);
        do_txn(rtype(6'h2C, 0), 6, 7, 0, 0, 1, 32'd42, 0, 0, 0, 4, 4, 0, 0);
        do_txn(itype(6'h04, 16'h0010), 9, 9, 0, 0, 1, 32'd0, 1, 1, 0, 1, 1, 0, 0);
        do_txn(itype(6'h05, 16'h0010), 9, 9, 0, 0, 1, 32'd0, 1, 0, 0, 1, 1, 0, 0);
        do_txn(itype(6'h08, 16'hFFFF), 1, 0, 0, 0, 1, 32'd0, 1, 0, 0, 1, 1, 1, 32'hFFFF_FFFF);
        do_txn(itype(6'h0C, 16'hFFFF), 32'h1234_5678, 0, 0, 0, 1, 32'h0000_5678, 0, 0, 0, 1, 1,
               1, 32'h0000_FFFF);
        do_txn(itype(6'h0F, 16'h1234), 32'hDEAD_BEEF, 0, 0, 0, 1, 32'h1234_0000, 0, 0, 0, 1, 1,
               0, 0);
        do_txn(rtype(6'h01, 5'd4), 0, 3, 0, 0, 1, 32'd48, 0, 0, 0, 1, 1, 1, 32'd4);
        do_txn(rtype(6'h2A, 0), 32'hFFFF_FFFF, 1, 0, 0, 1, 32'd1, 0, 0, 0, 1, 1, 0, 0);
        do_txn(rtype(6'h20, 0), 3, 4, 5, 1, 1, 32'd7, 0, 0, 0, 1, 1, 0, 0);
        do_txn(itype(6'h3F, 16'h0000), 5, 5, 0, 0, 1, 32'd0, 0, 0, 1, 1, 0, 0, 0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.IN_VALID = 1; bus.INSTR = rtype(6'h2C, 0); bus.RS_DATA = 3; bus.RT_DATA = 5;
        @(negedge clk);
        bus.IN_VALID = 0;
        @(negedge clk);
        chk("mid_mul_oprn", 32'(bus.ALU_OPRN), 32'd3);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst2_in_ready", 32'(bus.IN_READY), 32'd1);
        chk("rst2_res_valid", 32'(bus.RES_VALID), 32'd0);
        chk("rst2_oprn", 32'(bus.ALU_OPRN), 32'd0);
        chk("rst2_op1", bus.ALU_OP1, 32'd0);
        chk("rst2_op2", bus.ALU_OP2, 32'd0);
        chk("rst2_res_data", bus.RES_DATA, 32'd0);
        chk("rst2_flags", {29'd0, bus.RES_ZERO, bus.BR_TAKEN, bus.ILLEGAL}, 32'd0);

        for (int t = 0; t < 200; t++) begin
            logic [31:0] rs, rt;
            rs = $urandom;
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
            if ($urandom_range(0, 2) == 0) rt = 32'($urandom_range(0, 40));
            do_txn(rand_instr(), rs, rt, $urandom_range(0, 3), 1'($urandom), 0,
                   0, 0, 0, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential front-end that drives the 32-bit combinational ALU: accepts one decoded-register instruction per transaction, forms OP1/OP2/OPRN, holds them for a settle window, then captures OUT/ZERO.
- Presents the captured result, zero flag, branch decision and illegal flag to writeback through a valid/ready handshake.
- Sits between register-file read and writeback in the execute stage.

Parameters:
- SETTLE_CYC, 1, cycles ALU inputs are held before capture for non-multiply ops (>=1).
- MUL_CYC, 4, cycles held before capture for mul/muli (>= SETTLE_CYC).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  instruction and operands valid.
- IN_READY  output  1  block can accept; high only in IDLE.
- INSTR  input  32  instruction word.
- RS_DATA  input  32  rs register value.
- RT_DATA  input  32  rt register value.
- ALU_OP1  output  32  to ALU OP1.
- ALU_OP2  output  32  to ALU OP2.
- ALU_OPRN  output  6  to ALU OPRN; 0 (no-op) outside EXEC.
- ALU_OUT  input  32  from ALU OUT.
- ALU_ZERO  input  1  from ALU ZERO.
- RES_VALID  output  1  result available.
- RES_READY  input  1  writeback accepts result.
- RES_DATA  output  32  captured ALU result.
- RES_ZERO  output  1  captured ALU_ZERO.
- BR_TAKEN  output  1  beq/bne decision; 0 for all other ops.
- ILLEGAL  output  1  instruction not handled by this block.

Behaviour:
- Reset: state IDLE, counter 0. All outputs 0 except IN_READY=1. RST dominates IN_VALID. RST mid-EXEC/DONE discards the transaction; IDLE after the next edge.
- FSM IDLE -> EXEC -> DONE -> IDLE. No overlap; one transaction in flight.
- IDLE: on IN_VALID, latch INSTR, RS_DATA and RT_DATA, then decode.
  - Legal instruction: load counter with MUL_CYC (mul/muli) or SETTLE_CYC (others), go to EXEC.
  - Illegal instruction: go to DONE with ILLEGAL=1, RES_DATA=0; ALU_OPRN never leaves 0.
- EXEC: ALU_OP1, ALU_OP2 and ALU_OPRN are driven from latched state and are stable for exactly counter cycles. On the cycle the counter equals 1, capture ALU_OUT into RES_DATA and ALU_ZERO into RES_ZERO, compute BR_TAKEN, go to DONE.
- DONE: RES_VALID=1. RES_DATA, RES_ZERO, BR_TAKEN and ILLEGAL are held stable. When RES_READY=1, go to IDLE; IN_READY rises the following cycle.
- Latency: accept edge T0 gives RES_VALID high from edge T0+N, where N = SETTLE_CYC or MUL_CYC. Illegal instructions: T0+1.
- ALU_OP1/ALU_OP2 hold last latched values outside EXEC. Only ALU_OPRN is forced to 0.
- Decode (OPRN: add 1, sub 2, mul 3, shr 4, shl 5, and 6, or 7, nor 8, slt 9):
  - R-type opcode 0x00, OP1=rs, OP2=rt: funct 0x20 add, 0x22 sub, 0x2C mul, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
  - R-type shifts, OP1=rt, OP2={27'b0,shamt}: funct 0x01 sll -> 5, funct 0x02 srl -> 4.
  - Sign-extended imm, OP1=rs: addi 0x08 -> 1, muli 0x1D -> 3, slti 0x0A -> 9, lw 0x23 / sw 0x2B -> 1 (address).
  - Zero-extended imm, OP1=rs: andi 0x0C -> 6, ori 0x0D -> 7.
  - lui 0x0F: OP1={imm,16'b0}, OP2=0, OPRN 7.
  - beq 0x04 / bne 0x05: OP1=rs, OP2=rt, OPRN 2. BR_TAKEN = ALU_ZERO (beq) or !ALU_ZERO (bne).
  - All else, including jr and J-type: ILLEGAL.

Decomposition:
- prj_definition.v gains:
  - opcode and funct constants;
  - ALU OPRN constants (ALU_ADD..ALU_SLT, ALU_NOP=0);
  - FSM state encodings.
- One combinational sub-module, alu_instr_decode: INSTR, RS, RT -> OP1, OP2, OPRN, is_mul, is_beq, is_bne, illegal.
- FSM, counter and result registers stay in alu_issue_ctrl.

Test Plan:
- add rs=5, rt=7, SETTLE_CYC=1, accept at T0 -> ALU_OPRN=1 for one cycle; RES_VALID at T0+1 with RES_DATA=12, RES_ZERO=0.
- mul rs=6, rt=7, MUL_CYC=4 -> ALU_OPRN=3 held exactly 4 cycles; RES_DATA=42 at T0+4.
- beq rs=rt=9 -> RES_ZERO=1, BR_TAKEN=1; bne same operands -> BR_TAKEN=0.
- Immediate extension:
  - addi rs=1, imm=0xFFFF -> ALU_OP2=0xFFFFFFFF, RES_DATA=0, RES_ZERO=1.
  - andi imm=0xFFFF -> ALU_OP2=0x0000FFFF.
  - lui imm=0x1234 -> RES_DATA=0x12340000.
- RES_READY low 5 cycles in DONE, IN_VALID high throughout -> RES_* stable, IN_READY=0, no new accept. RES_READY=1 -> IDLE next cycle.
- Opcode 0x3F -> ILLEGAL=1, ALU_OPRN stays 0, RES_VALID at T0+1. RST during mul EXEC -> next edge IDLE, all outputs 0, IN_READY=1.
